// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter with a small byte FIFO.
// The register window is 16 bytes:
//   0x0 TXDATA (write pushes one byte)
//   0x4 STATUS (full, empty, busy, sticky overflow, count)
// Each frame is one start bit, eight data bits sent LSB first, and one stop bit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high; pops the FIFO head as soon as a byte is queued
// START | start bit (line low) for one bit time
// DATA  | eight data bits, LSB first, shift register moves right
// STOP  | stop bit (line high); chains straight into the next START
//       | when the FIFO still holds data
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_read_data,
  output logic        tx
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [3:0]        DEPTH_CNT = 4'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [3:0]        count;
  logic              overflow;

  logic              sel;
  logic [3:0]        offset;
  logic              wr_txdata;
  logic              push_ok;
  logic              push_drop;
  logic              ovf_clear;
  logic              bit_end;
  logic              pop;
  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              busy;
  logic [31:0]       status_word;

  // Upper store-data bits and the upper byte lanes have no register behind them.
  logic unused_bits;
  assign unused_bits = ^{bus_write_data[31:8], bus_byte_enable[3:1]};

  // Address decode and the bus-side events it produces.
  assign sel       = (bus_address[31:4] == BASE_ADDR[31:4]);
  assign offset    = bus_address[3:0];
  assign wr_txdata = sel && bus_write_enable && (offset == OFF_TXDATA) && bus_byte_enable[0];
  assign push_ok   = wr_txdata && (count < DEPTH_CNT);
  assign push_drop = wr_txdata && !push_ok;
  assign ovf_clear = sel && bus_write_enable && (offset == OFF_STATUS) &&
                     bus_byte_enable[0] && bus_write_data[3];

  // Pops happen only when the FSM takes a new byte. That can be from IDLE, or
  // on the last cycle of a stop bit, which is what gives gap-free frames.
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign pop       = (count != 4'd0) &&
                     ((state == IDLE) || ((state == STOP) && bit_end));
  assign fifo_head = fifo_mem[rd_ptr];

  assign fifo_full   = (count == DEPTH_CNT);
  assign fifo_empty  = (count == 4'd0);
  assign busy        = (state != IDLE);
  assign status_word = {20'd0, count, 4'd0, overflow, busy, fifo_empty, fifo_full};

  // Combinational load data; unselected or unused offsets read as zero.
  always_comb begin
    bus_read_data = 32'd0;
    if (bus_read_enable && sel) begin
      case (offset)
        OFF_STATUS: bus_read_data = status_word;
        default:    bus_read_data = 32'd0;
      endcase
    end
  end

  // FIFO storage. It has no reset because the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      fifo_mem[wr_ptr] <= bus_write_data[7:0];
    end
  end

  // Write pointer wraps at the last entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (push_ok) begin
      wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer advances whenever the FSM takes the head byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Occupancy. A simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow. A dropped push sets it; a write-one to STATUS bit 3 clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

  // Transmit FSM. tx is registered alongside the state, so the line follows
  // the state with no combinational glitches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
      tx        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift_reg <= fifo_head;
            state     <= START;
            tx        <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= fifo_head;
              state     <= START;
              tx        <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule
